nco_sweep_ctrl: RTL and testbench
=================================

# nco_sweep_ctrl

Phase-increment scheduler that sequences the NCO core for stepped-frequency sweeps. It accepts a sweep configuration through a valid/ready handshake and then drives the NCO `phi_inc_i` and `clken` inputs. Each increment is held for a programmable dwell, after which the controller steps by a signed delta. After the last step it keeps the NCO clocked long enough to flush its pipeline, then reports completion.

## Interface
- `APR`, 32: phase-increment width; matches NCO `apr`.
- `CNTW`, 16: step-count width.
- `DWW`, 16: dwell-counter width.
- `LAT`, 6: NCO pipeline flush length in cycles; matches NCO input-to-`out_valid` latency.

Ports:
- `clk` in 1: single clock; one clock domain, shared with the NCO.
- `reset` in 1: synchronous, active-high reset.
- `cfg_valid` in 1: configuration offered.
- `cfg_ready` out 1: configuration accepted when `cfg_valid && cfg_ready`.
- `cfg_start_inc` in APR: first phase increment, unsigned.
- `cfg_step_inc` in APR: per-step delta, two's complement.
- `cfg_num_steps` in CNTW: number of steps; 0 is treated as 1.
- `cfg_dwell` in DWW: cycles per step; 0 is treated as 1.
- `cfg_repeat` in 1: 0 = one-shot sweep, 1 = restart the sweep continuously.
- `start` in 1: begin the sweep; level, sampled in IDLE only.
- `abort` in 1: terminate the sweep immediately.
- `busy` out 1: high in RUN and FLUSH.
- `done` out 1: one-cycle pulse on normal completion.
- `step_strobe` out 1: one-cycle pulse on the first cycle of each step.
- `step_idx` out CNTW: index of the current step.
- `nco_clken` out 1: drives NCO `clken`.
- `nco_phi_inc` out APR: drives NCO `phi_inc_i`.

## Operation
- States are IDLE, RUN and FLUSH.
- All outputs are registered except `cfg_ready`, which equals (state == IDLE).
- Reset values: state IDLE, `cfg_loaded` 0. All outputs are 0 except `cfg_ready`, which is 1.
- **IDLE**
  - A handshake loads the shadow registers and sets `cfg_loaded`.
  - `start && cfg_loaded && !abort` moves the block to RUN. `start` without a loaded configuration is ignored.
  - A handshake and `start` in the same cycle use the newly loaded configuration.
- **RUN**
  - `nco_clken` = 1 and `nco_phi_inc` = current increment.
  - The dwell counter counts to max(dwell,1). At the end of a dwell:
    - If `step_idx` = max(num_steps,1) − 1 and `cfg_repeat` = 1: reload `cfg_start_inc` and set `step_idx` to 0.
    - If `step_idx` = max(num_steps,1) − 1 and `cfg_repeat` = 0: go to FLUSH.
    - Otherwise: increment ← increment + step, modulo 2^APR (silent wrap), and `step_idx` + 1.
  - `step_strobe` pulses with every new increment, including reloads in repeat mode.
- **FLUSH**
  - `nco_clken` = 1 and the last increment is held for LAT cycles.
  - The block then returns to IDLE with `done` = 1, `busy` = 0, `nco_clken` = 0 and `nco_phi_inc` = 0.
- **abort**
  - In RUN or FLUSH, abort takes effect on the next edge: IDLE, all outputs zeroed, no `done` pulse.
  - `cfg_loaded` is retained after an abort.
  - Abort has priority over `start` and over step or flush transitions in the same cycle.
- Reset mid-operation returns the block to its reset values on the next edge and clears `cfg_loaded`.

## Timing
- `start` sampled at edge T gives, from T+1: `busy` = 1, `nco_clken` = 1, `nco_phi_inc` = start_inc, `step_idx` = 0, `step_strobe` = 1.
- Step k occupies cycles T+1+k·D through T+(k+1)·D, where D = max(dwell,1).
- FLUSH occupies the LAT cycles after the last RUN cycle. `done` appears at T+1+N·D+LAT, where N = max(num_steps,1).
- `cfg_ready` is low from T+1 until the `done` or abort cycle. A new `start` is accepted at the earliest one cycle after `done`.

## Structure
- Package `nco_ctrl_pkg` holds:
  - the state enum (IDLE/RUN/FLUSH);
  - the mode constants (ONESHOT/REPEAT);
  - the default LAT constant, shared with the NCO wrapper.
- Sub-module `nco_dwell_cnt`: a loadable down-counter with a terminal-count pulse, used for both dwell and flush counting.

## Test plan
- **Basic sweep.** start=0x01000000, step=0x00100000, N=4, D=3, one-shot.
  - `nco_phi_inc` = 0x01000000×3, 0x01100000×3, 0x01200000×3, 0x01300000×3.
  - 6 flush cycles hold 0x01300000.
  - `done` at T+19.
  - 4 `step_strobe` pulses.
- **Wrap and negative step.**
  - start=0xFFFFFFF0, step=0x20, N=2 → second increment 0x00000010.
  - start=0x100, step=0xFFFFFF00, N=3 → 0x100, 0x000, 0xFFFFFF00.
- **Zero-value handling.** N=0, D=0 → a single 1-cycle step, then FLUSH; `done` at T+8.
- **Repeat mode.** N=2, D=1 → increments alternate start, start+step indefinitely. `step_idx` alternates 0/1. No `done`.
- **Abort and start qualification.**
  - Abort in the middle of step 2 → next cycle `busy` = 0, `nco_clken` = 0, `nco_phi_inc` = 0, no `done`.
  - A subsequent `start` without reconfiguring replays the same sweep.
  - `start` after reset without a configuration → no response.
- **Handshake and reset.**
  - `cfg_valid` while busy → `cfg_ready` = 0 and the shadow registers are unchanged.
  - Reset asserted in FLUSH → next cycle all outputs are at reset values; `start` is then ignored until a reconfiguration.

Source files
------------

// File: rtl/nco_sweep_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nco_ctrl_pkg
// Description : Shared types and constants for the NCO sweep controller and
//               the NCO wrapper (controller state, sweep modes, flush length).
// Revision    : 1.0 - initial release
// ============================================================================
package nco_ctrl_pkg;

   // Controller state; explicit 2-bit encoding.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   // Sweep modes as carried by cfg_repeat.
   localparam logic c_ONESHOT = 1'b0;
   localparam logic c_REPEAT  = 1'b1;

   // NCO input-to-out_valid latency; the controller flushes this many cycles.
   localparam int   c_LAT_DEFAULT = 6;

endpackage : nco_ctrl_pkg
`default_nettype wire

// File: rtl/nco_sweep_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : nco_sweep_ctrl_if
// Description : Configuration handshake, sweep control and NCO drive signals
//               of the sweep controller. master = host side, slave = controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface nco_sweep_ctrl_if #(
   parameter int APR  = 32,
   parameter int CNTW = 16,
   parameter int DWW  = 16
) ();
   logic            cfg_valid;
   logic            cfg_ready;
   logic [APR-1:0]  cfg_start_inc;
   logic [APR-1:0]  cfg_step_inc;
   logic [CNTW-1:0] cfg_num_steps;
   logic [DWW-1:0]  cfg_dwell;
   logic            cfg_repeat;
   logic            start;
   logic            abort;
   logic            busy;
   logic            done;
   logic            step_strobe;
   logic [CNTW-1:0] step_idx;
   logic            nco_clken;
   logic [APR-1:0]  nco_phi_inc;

   modport master (
      output cfg_valid, cfg_start_inc, cfg_step_inc, cfg_num_steps,
             cfg_dwell, cfg_repeat, start, abort,
      input  cfg_ready, busy, done, step_strobe, step_idx, nco_clken,
             nco_phi_inc
   );

   modport slave (
      input  cfg_valid, cfg_start_inc, cfg_step_inc, cfg_num_steps,
             cfg_dwell, cfg_repeat, start, abort,
      output cfg_ready, busy, done, step_strobe, step_idx, nco_clken,
             nco_phi_inc
   );
endinterface : nco_sweep_ctrl_if
`default_nettype wire

// File: rtl/nco_sweep_ctrl_dwell_cnt.sv
`default_nettype none
// ============================================================================
// Module      : nco_dwell_cnt
// Description : Loadable down-counter. Loading a length L (L >= 1) makes o_tc
//               assert on the L-th cycle after the load edge; used for both
//               dwell and flush timing.
// Revision    : 1.0 - initial release
// ============================================================================
module nco_dwell_cnt #(
   parameter int W = 16
) (
   input  wire logic         clk,
   input  wire logic         rst,
   input  wire logic         i_load,
   input  wire logic [W-1:0] i_load_val,
   output logic              o_tc
);

   logic [W-1:0] r_cnt;

   // Load length-1, then count down and park at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val - W'(1);
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - W'(1);
      end
   end

   assign o_tc = (r_cnt == '0);

endmodule : nco_dwell_cnt
`default_nettype wire

// File: rtl/nco_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nco_sweep_ctrl
// Description : Stepped-frequency sweep scheduler driving NCO phi_inc/clken.
//               Holds each increment for a dwell, steps by a signed delta,
//               flushes the NCO pipeline and pulses done.
// Revision    : 1.0 - initial release
// ============================================================================
module nco_sweep_ctrl
   import nco_ctrl_pkg::*;
#(
   parameter int APR  = 32,
   parameter int CNTW = 16,
   parameter int DWW  = 16,
   parameter int LAT  = c_LAT_DEFAULT
) (
   input  wire logic       clk,
   input  wire logic       reset,
   nco_sweep_ctrl_if.slave bus
);

   // A zero flush length would underflow the counter load.
   localparam int c_FLUSH_LEN = (LAT < 1) ? 1 : LAT;

   state_t          r_state, w_state_nxt;

   // Shadow configuration; counts are stored already clamped to >= 1.
   logic [APR-1:0]  r_cfg_start;
   logic [APR-1:0]  r_cfg_step;
   logic [CNTW-1:0] r_cfg_last_idx;
   logic [DWW-1:0]  r_cfg_dwell;
   logic            r_cfg_repeat;
   logic            r_cfg_loaded;

   logic            r_busy, r_done, r_strobe, r_clken;
   logic [CNTW-1:0] r_step_idx;
   logic [APR-1:0]  r_phi_inc;

   logic            w_busy_nxt, w_done_nxt, w_strobe_nxt, w_clken_nxt;
   logic [CNTW-1:0] w_idx_nxt;
   logic [APR-1:0]  w_phi_nxt;
   logic            w_cnt_load, w_cnt_tc;
   logic [DWW-1:0]  w_cnt_val;

   logic            w_hs;
   logic [CNTW-1:0] w_in_last_idx;
   logic [DWW-1:0]  w_in_dwell;
   logic [APR-1:0]  w_eff_start;
   logic [DWW-1:0]  w_eff_dwell;
   logic            w_eff_loaded;

   assign bus.cfg_ready = (r_state == ST_IDLE);
   assign w_hs          = bus.cfg_valid && (r_state == ST_IDLE);
   assign w_in_last_idx = (bus.cfg_num_steps == '0) ? '0 : bus.cfg_num_steps - CNTW'(1);
   assign w_in_dwell    = (bus.cfg_dwell == '0) ? DWW'(1) : bus.cfg_dwell;

   // A handshake in the start cycle takes effect for that start.
   assign w_eff_start  = w_hs ? bus.cfg_start_inc : r_cfg_start;
   assign w_eff_dwell  = w_hs ? w_in_dwell : r_cfg_dwell;
   assign w_eff_loaded = w_hs || r_cfg_loaded;

   nco_dwell_cnt #(.W(DWW)) u_cnt (
      .clk        (clk),
      .rst        (reset),
      .i_load     (w_cnt_load),
      .i_load_val (w_cnt_val),
      .o_tc       (w_cnt_tc)
   );

   // Shadow configuration capture; survives abort, cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cfg_start    <= '0;
         r_cfg_step     <= '0;
         r_cfg_last_idx <= '0;
         r_cfg_dwell    <= DWW'(1);
         r_cfg_repeat   <= c_ONESHOT;
         r_cfg_loaded   <= 1'b0;
      end else if (w_hs) begin
         r_cfg_start    <= bus.cfg_start_inc;
         r_cfg_step     <= bus.cfg_step_inc;
         r_cfg_last_idx <= w_in_last_idx;
         r_cfg_dwell    <= w_in_dwell;
         r_cfg_repeat   <= bus.cfg_repeat;
         r_cfg_loaded   <= 1'b1;
      end
   end

   // State register and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_strobe   <= 1'b0;
         r_clken    <= 1'b0;
         r_step_idx <= '0;
         r_phi_inc  <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_busy     <= w_busy_nxt;
         r_done     <= w_done_nxt;
         r_strobe   <= w_strobe_nxt;
         r_clken    <= w_clken_nxt;
         r_step_idx <= w_idx_nxt;
         r_phi_inc  <= w_phi_nxt;
      end
   end

   // Next-state and next-output logic; abort outranks every other transition.
   always_comb begin
      w_state_nxt  = r_state;
      w_busy_nxt   = r_busy;
      w_done_nxt   = 1'b0;
      w_strobe_nxt = 1'b0;
      w_clken_nxt  = r_clken;
      w_idx_nxt    = r_step_idx;
      w_phi_nxt    = r_phi_inc;
      w_cnt_load   = 1'b0;
      w_cnt_val    = r_cfg_dwell;

      unique case (r_state)
         ST_IDLE: begin
            w_busy_nxt  = 1'b0;
            w_clken_nxt = 1'b0;
            w_idx_nxt   = '0;
            w_phi_nxt   = '0;
            if (bus.start && w_eff_loaded && !bus.abort) begin
               w_state_nxt  = ST_RUN;
               w_busy_nxt   = 1'b1;
               w_clken_nxt  = 1'b1;
               w_phi_nxt    = w_eff_start;
               w_strobe_nxt = 1'b1;
               w_cnt_load   = 1'b1;
               w_cnt_val    = w_eff_dwell;
            end
         end
         ST_RUN: begin
            if (bus.abort) begin
               w_state_nxt = ST_IDLE;
               w_busy_nxt  = 1'b0;
               w_clken_nxt = 1'b0;
               w_idx_nxt   = '0;
               w_phi_nxt   = '0;
            end else if (w_cnt_tc) begin
               if (r_step_idx == r_cfg_last_idx && r_cfg_repeat != c_REPEAT) begin
                  w_state_nxt = ST_FLUSH;
                  w_cnt_load  = 1'b1;
                  w_cnt_val   = DWW'(c_FLUSH_LEN);
               end else begin
                  w_strobe_nxt = 1'b1;
                  w_cnt_load   = 1'b1;
                  if (r_step_idx == r_cfg_last_idx) begin
                     w_idx_nxt = '0;
                     w_phi_nxt = r_cfg_start;
                  end else begin
                     w_idx_nxt = r_step_idx + CNTW'(1);
                     w_phi_nxt = r_phi_inc + r_cfg_step;
                  end
               end
            end
         end
         ST_FLUSH: begin
            if (bus.abort || w_cnt_tc) begin
               w_state_nxt = ST_IDLE;
               w_busy_nxt  = 1'b0;
               w_clken_nxt = 1'b0;
               w_idx_nxt   = '0;
               w_phi_nxt   = '0;
               w_done_nxt  = !bus.abort;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.step_strobe = r_strobe;
   assign bus.step_idx    = r_step_idx;
   assign bus.nco_clken   = r_clken;
   assign bus.nco_phi_inc = r_phi_inc;

endmodule : nco_sweep_ctrl
`default_nettype wire

// File: tb/tb_nco_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_nco_sweep_ctrl
// Description : Self-checking bench for nco_sweep_ctrl: directed vector table,
//               corner-case sequences and random sweeps against a cycle-offset
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nco_sweep_ctrl;

   localparam int LAT = 6;

   typedef struct {
      logic [31:0] start;
      logic [31:0] step;
      logic [15:0] n;
      logic [15:0] d;
      logic        rep;
   } cfg_t;

   typedef struct {
      logic        busy;
      logic        done;
      logic        strobe;
      logic        clken;
      logic        ready;
      logic [15:0] idx;
      logic [31:0] phi;
   } obs_t;

   typedef struct {
      cfg_t        c;
      int          mode;        // 0 separate handshake, 1 handshake with start
      int          exp_done_t;
      int          exp_strobes;
      logic [31:0] exp_last;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   nco_sweep_ctrl_if #(.APR(32), .CNTW(16), .DWW(16)) bus ();

   nco_sweep_ctrl #(.APR(32), .CNTW(16), .DWW(16), .LAT(LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Expected outputs t cycles after the edge that sampled start.
   function automatic obs_t model(cfg_t c, int t);
      obs_t e;
      int   nn, dd, run_len, k;
      nn      = (c.n == 16'd0) ? 1 : int'(c.n);
      dd      = (c.d == 16'd0) ? 1 : int'(c.d);
      run_len = nn * dd;
      e.busy = 1'b0; e.done = 1'b0; e.strobe = 1'b0; e.clken = 1'b0;
      e.ready = 1'b1; e.idx = 16'd0; e.phi = 32'd0;
      if (c.rep || t <= run_len) begin
         k = (t - 1) / dd;
         if (c.rep) k = k % nn;
         e.busy = 1'b1; e.clken = 1'b1; e.ready = 1'b0;
         e.idx = 16'(k);
         e.phi = c.start + 32'(k) * c.step;
         e.strobe = ((t - 1) % dd) == 0;
      end else if (t <= run_len + LAT) begin
         e.busy = 1'b1; e.clken = 1'b1; e.ready = 1'b0;
         e.idx = 16'(nn - 1);
         e.phi = c.start + 32'(nn - 1) * c.step;
      end else if (t == run_len + LAT + 1) begin
         e.done = 1'b1;
      end
      return e;
   endfunction

   function automatic obs_t idle_exp();
      obs_t e;
      e.busy = 1'b0; e.done = 1'b0; e.strobe = 1'b0; e.clken = 1'b0;
      e.ready = 1'b1; e.idx = 16'd0; e.phi = 32'd0;
      return e;
   endfunction

   function automatic obs_t sample();
      obs_t a;
      a.busy = bus.busy; a.done = bus.done; a.strobe = bus.step_strobe;
      a.clken = bus.nco_clken; a.ready = bus.cfg_ready;
      a.idx = bus.step_idx; a.phi = bus.nco_phi_inc;
      return a;
   endfunction

   task automatic check(string name, obs_t e);
      obs_t a;
      a = sample();
      total++;
      if (a.busy !== e.busy || a.done !== e.done || a.strobe !== e.strobe ||
          a.clken !== e.clken || a.ready !== e.ready || a.idx !== e.idx ||
          a.phi !== e.phi) begin
         bad++;
         $display("FAIL %s @%0t: got busy=%0b done=%0b stb=%0b clken=%0b rdy=%0b idx=%0d phi=%h; want busy=%0b done=%0b stb=%0b clken=%0b rdy=%0b idx=%0d phi=%h",
                  name, $time, a.busy, a.done, a.strobe, a.clken, a.ready, a.idx, a.phi,
                  e.busy, e.done, e.strobe, e.clken, e.ready, e.idx, e.phi);
      end
   endtask

   task automatic check_int(string name, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%h) want %0d (0x%h)", name, act, act, exp, exp);
      end
   endtask

   task automatic step_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_cfg(cfg_t c);
      bus.cfg_start_inc = c.start;
      bus.cfg_step_inc  = c.step;
      bus.cfg_num_steps = c.n;
      bus.cfg_dwell     = c.d;
      bus.cfg_repeat    = c.rep;
   endtask

   task automatic do_cfg(cfg_t c);
      drive_cfg(c);
      bus.cfg_valid = 1'b1;
      step_cycle();
      bus.cfg_valid = 1'b0;
   endtask

   // Returns at the sample point of cycle T+1.
   task automatic launch(cfg_t c, bit with_cfg);
      if (with_cfg) drive_cfg(c);
      bus.cfg_valid = with_cfg;
      bus.start     = 1'b1;
      step_cycle();
      bus.start     = 1'b0;
      bus.cfg_valid = 1'b0;
   endtask

   // mode: 0 handshake then start, 1 handshake with start, 2 reuse shadow.
   // limit 0 runs one cycle past done; inject pokes cfg_valid while busy.
   task automatic run_and_check(string name, cfg_t c, int mode, bit inject, int limit,
                                output int done_t, output int strobes,
                                output logic [31:0] last_inc);
      obs_t a;
      int   lim, nn, dd;
      nn = (c.n == 16'd0) ? 1 : int'(c.n);
      dd = (c.d == 16'd0) ? 1 : int'(c.d);
      lim = (limit > 0) ? limit : nn * dd + LAT + 2;
      done_t = 0; strobes = 0; last_inc = 32'd0;
      if (mode == 0) do_cfg(c);
      launch(c, mode == 1);
      for (int t = 1; t <= lim; t++) begin
         if (inject && t == 2) begin
            bus.cfg_start_inc = ~c.start;
            bus.cfg_step_inc  = ~c.step;
            bus.cfg_num_steps = 16'd9;
            bus.cfg_dwell     = 16'd7;
            bus.cfg_valid     = 1'b1;
         end
         if (inject && t == 3) bus.cfg_valid = 1'b0;
         check(name, model(c, t));
         a = sample();
         if (a.done && done_t == 0) done_t = t;
         if (a.strobe) strobes++;
         if (a.clken) last_inc = a.phi;
         step_cycle();
      end
   endtask

   vec_t        vecs[4];
   cfg_t        basic, rc, nc;
   int          dt, ns, dones;
   logic [31:0] li;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      basic = '{start:32'h0100_0000, step:32'h0010_0000, n:16'd4, d:16'd3, rep:1'b0};
      nc    = '{start:32'h0000_0100, step:32'hFFFF_FF00, n:16'd3, d:16'd2, rep:1'b0};
      vecs[0] = '{c:basic, mode:0, exp_done_t:19, exp_strobes:4, exp_last:32'h0130_0000};
      vecs[1] = '{c:'{start:32'hFFFF_FFF0, step:32'h20, n:16'd2, d:16'd1, rep:1'b0},
                  mode:1, exp_done_t:9, exp_strobes:2, exp_last:32'h0000_0010};
      vecs[2] = '{c:nc, mode:0, exp_done_t:13, exp_strobes:3, exp_last:32'hFFFF_FF00};
      vecs[3] = '{c:'{start:32'h0000_5555, step:32'h7, n:16'd0, d:16'd0, rep:1'b0},
                  mode:1, exp_done_t:8, exp_strobes:1, exp_last:32'h0000_5555};

      bus.cfg_valid = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;
      drive_cfg(basic);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check("reset_state", idle_exp());

      // start with no configuration ever loaded
      bus.start = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step_cycle();
         check("start_no_cfg", idle_exp());
      end
      bus.start = 1'b0;
      step_cycle();

      // directed vector table
      foreach (vecs[i]) begin
         run_and_check($sformatf("vec%0d", i), vecs[i].c, vecs[i].mode, 1'b0, 0, dt, ns, li);
         check_int($sformatf("vec%0d_done_t", i), dt, vecs[i].exp_done_t);
         check_int($sformatf("vec%0d_strobes", i), ns, vecs[i].exp_strobes);
         check_int($sformatf("vec%0d_last_inc", i), int'(li), int'(vecs[i].exp_last));
      end

      // repeat mode, then abort
      rc = '{start:32'h0000_1000, step:32'h0000_0010, n:16'd2, d:16'd1, rep:1'b1};
      run_and_check("repeat", rc, 0, 1'b0, 12, dt, ns, li);
      check_int("repeat_no_done", dt, 0);
      check_int("repeat_strobes", ns, 12);
      bus.abort = 1'b1;
      step_cycle();
      bus.abort = 1'b0;
      check("repeat_abort", idle_exp());

      // abort in the middle of step 2
      do_cfg(basic);
      launch(basic, 1'b0);
      for (int t = 1; t <= 8; t++) begin
         check("abort_pre", model(basic, t));
         if (t < 8) step_cycle();
      end
      bus.abort = 1'b1;
      step_cycle();
      bus.abort = 1'b0;
      check("abort_next", idle_exp());
      dones = 0;
      for (int i = 0; i < 20; i++) begin
         step_cycle();
         if (bus.done) dones++;
      end
      check_int("abort_no_done", dones, 0);
      run_and_check("abort_replay", basic, 2, 1'b0, 0, dt, ns, li);
      check_int("abort_replay_done_t", dt, 19);

      // cfg_valid while busy must not disturb the shadow registers
      run_and_check("busy_cfg", nc, 0, 1'b1, 0, dt, ns, li);
      run_and_check("busy_cfg_replay", nc, 2, 1'b0, 0, dt, ns, li);
      check_int("busy_cfg_replay_last", int'(li), int'(32'hFFFF_FF00));

      // reset while flushing clears the configuration
      do_cfg(basic);
      launch(basic, 1'b0);
      for (int t = 1; t <= 14; t++) begin
         check("flush_pre", model(basic, t));
         if (t < 14) step_cycle();
      end
      reset = 1'b1;
      step_cycle();
      reset = 1'b0;
      check("reset_in_flush", idle_exp());
      bus.start = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step_cycle();
         check("start_after_reset", idle_exp());
      end
      bus.start = 1'b0;
      step_cycle();
      run_and_check("reconfig", basic, 0, 1'b0, 0, dt, ns, li);
      check_int("reconfig_done_t", dt, 19);

      // random one-shot sweeps
      for (int i = 0; i < 25; i++) begin
         cfg_t rcfg;
         int   nn, dd;
         rcfg.start = $urandom;
         rcfg.step  = $urandom;
         rcfg.n     = 16'($urandom_range(0, 5));
         rcfg.d     = 16'($urandom_range(0, 4));
         rcfg.rep   = 1'b0;
         nn = (rcfg.n == 16'd0) ? 1 : int'(rcfg.n);
         dd = (rcfg.d == 16'd0) ? 1 : int'(rcfg.d);
         run_and_check("random", rcfg, int'($urandom_range(0, 1)), 1'b0, 0, dt, ns, li);
         check_int("random_done_t", dt, nn * dd + LAT + 1);
         check_int("random_strobes", ns, nn);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_nco_sweep_ctrl
`default_nettype wire
